// File: rtl/key_entry_pkg.sv
// Shared definitions for the keypad code-entry lock: one-hot FSM state codes and keypad key codes.
package key_entry_pkg;

    typedef logic [4:0] state_t;

    localparam state_t ST_ENTRY    = 5'b00001;
    localparam state_t ST_CHECK    = 5'b00010;
    localparam state_t ST_UNLOCKED = 5'b00100;
    localparam state_t ST_LOCKOUT  = 5'b01000;
    localparam state_t ST_SET_PW   = 5'b10000;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_SETPW = 4'hD;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'h9;
    endfunction

endpackage

// File: rtl/key_press_edge.sv
// Turns the scanner's level key_valid into a single registered press pulse and
// captures the key code on that pulse.
module key_press_edge (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output logic       press,
    output logic [3:0] key
);

    logic kv_d;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            kv_d  <= 1'b0;
            press <= 1'b0;
            key   <= 4'h0;
        end else begin
            kv_d  <= key_valid;
            press <= key_valid & ~kv_d;
            if (key_valid & ~kv_d) begin
                key <= key_value;
            end
        end
    end

endmodule

// File: rtl/key_entry_lock.sv
// Keypad code-entry lock: edits an entry buffer, checks it against the password and drives
// unlock/lockout. Defining KEY_ENTRY_PW_CHANGE_EN enables changing the password while unlocked.
module key_entry_lock
    import key_entry_pkg::*;
#(
    parameter int unsigned         DIGITS        = 4,
    parameter logic [DIGITS*4-1:0] PASSWORD      = 16'h1234,
    parameter int unsigned         UNLOCK_CYCLES = 500_000_000,
    parameter int unsigned         LOCK_CYCLES   = 1_000_000_000,
    parameter int unsigned         MAX_FAIL      = 3
) (
    input  logic                             clk,
    input  logic                             reset_p,
    input  logic [3:0]                       key_value,
    input  logic                             key_valid,
    output logic [DIGITS*4-1:0]              entry,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic                             unlocked,
    output logic                             alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    localparam logic [CW-1:0] FULL        = CW'(DIGITS);
    localparam logic [FW-1:0] FAIL_LIMIT  = FW'(MAX_FAIL);
    localparam logic [31:0]   UNLOCK_LOAD = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0]   LOCK_LOAD   = 32'(LOCK_CYCLES - 1);

    logic          press;
    logic [3:0]    key;
    state_t        state;
    state_t        state_n;
    logic [31:0]   timer;
    logic [31:0]   timer_n;
    logic [DW-1:0] entry_n;
    logic [DW-1:0] edit_entry;
    logic [DW-1:0] pw_reg;
    logic [CW-1:0] count_n;
    logic [CW-1:0] edit_count;
    logic [FW-1:0] fail_n;
    logic          code_match;

    key_press_edge u_edge (
        .clk       (clk),
        .reset_p   (reset_p),
        .key_value (key_value),
        .key_valid (key_valid),
        .press     (press),
        .key       (key)
    );

`ifdef KEY_ENTRY_PW_CHANGE_EN
    logic [DW-1:0] pw_n;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            pw_reg <= PASSWORD;
        end else begin
            pw_reg <= pw_n;
        end
    end
`else
    assign pw_reg = PASSWORD;
`endif

    // Buffer editing shared by ENTRY and SET_PW; enter and unused codes leave it unchanged.
    always_comb begin
        edit_entry = entry;
        edit_count = digit_count;
        if (press) begin
            if (is_digit(key)) begin
                if (digit_count < FULL) begin
                    edit_entry = (entry << 4) | DW'(key);
                    edit_count = digit_count + CW'(1);
                end
            end else if (key == KEY_BACK) begin
                if (digit_count != '0) begin
                    edit_entry = entry >> 4;
                    edit_count = digit_count - CW'(1);
                end
            end else if (key == KEY_CLEAR) begin
                edit_entry = '0;
                edit_count = '0;
            end
        end
    end

    assign code_match = (digit_count == FULL) && (entry == pw_reg);

    always_comb begin
        state_n = state;
        entry_n = entry;
        count_n = digit_count;
        fail_n  = fail_count;
        timer_n = timer;
`ifdef KEY_ENTRY_PW_CHANGE_EN
        pw_n    = pw_reg;
`endif
        case (state)
            ST_ENTRY: begin
                entry_n = edit_entry;
                count_n = edit_count;
                if (press && key == KEY_ENTER) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                entry_n = '0;
                count_n = '0;
                if (code_match) begin
                    state_n = ST_UNLOCKED;
                    fail_n  = '0;
                    timer_n = UNLOCK_LOAD;
                end else begin
                    fail_n = fail_count + FW'(1);
                    if (fail_n == FAIL_LIMIT) begin
                        state_n = ST_LOCKOUT;
                        timer_n = LOCK_LOAD;
                    end else begin
                        state_n = ST_ENTRY;
                    end
                end
            end
            ST_UNLOCKED: begin
                // Expiry is tested first so a press landing on the last cycle is dropped.
                if (timer == '0 || (press && key == KEY_CLEAR)) begin
                    state_n = ST_ENTRY;
                    entry_n = '0;
                    count_n = '0;
                end
`ifdef KEY_ENTRY_PW_CHANGE_EN
                else if (press && key == KEY_SETPW) begin
                    state_n = ST_SET_PW;
                    entry_n = '0;
                    count_n = '0;
                end
`endif
                else begin
                    timer_n = timer - 32'd1;
                end
            end
            ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = ST_ENTRY;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
`ifdef KEY_ENTRY_PW_CHANGE_EN
            ST_SET_PW: begin
                entry_n = edit_entry;
                count_n = edit_count;
                if (press && key == KEY_ENTER && digit_count == FULL) begin
                    pw_n    = entry;
                    state_n = ST_ENTRY;
                    entry_n = '0;
                    count_n = '0;
                end else if (press && key == KEY_CLEAR) begin
                    state_n = ST_ENTRY;
                end
            end
`endif
            default: begin
                state_n = ST_ENTRY;
                entry_n = '0;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state       <= ST_ENTRY;
            entry       <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            timer       <= '0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_n;
            entry       <= entry_n;
            digit_count <= count_n;
            fail_count  <= fail_n;
            timer       <= timer_n;
            unlocked    <= (state_n == ST_UNLOCKED);
            alarm       <= (state_n == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_key_entry_lock.sv
// Bench for key_entry_lock with short timers: directed scenarios plus random key sequences
// checked against a digit-queue model of the lock.
module tb_key_entry_lock;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  fail_count;

    int checks = 0;
    int errors = 0;

    // Reference model: digits held in typing order, consecutive failures, current password.
    int          m_digits[$];
    int          m_fail;
    logic [15:0] m_pw;

    logic [3:0]  edit_keys  [13] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'h5, 4'h6, 4'hC};
    logic [15:0] edit_entry [13] = '{16'h1, 16'h12, 16'h123, 16'h1234, 16'h1234, 16'h123, 16'h12, 16'h1, 16'h0,
                                     16'h0, 16'h5, 16'h56, 16'h0};
    logic [2:0]  edit_count [13] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0};

    key_entry_lock #(
        .DIGITS        (4),
        .PASSWORD      (16'h1234),
        .UNLOCK_CYCLES (20),
        .LOCK_CYCLES   (40),
        .MAX_FAIL      (3)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .entry       (entry),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] m_entry();
        logic [15:0] e;
        e = '0;
        foreach (m_digits[i]) e = (e << 4) | 16'(m_digits[i]);
        return e;
    endfunction

    task automatic model_edit(input logic [3:0] k);
        if (k <= 4'h9) begin
            if (m_digits.size() < 4) m_digits.push_back(int'(k));
        end else if (k == 4'hB) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (k == 4'hC) begin
            m_digits.delete();
        end
    endtask

    task automatic press_key(input logic [3:0] k, input int hold, input int gap);
        @(negedge clk);
        key_value = k;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic type_code(input logic [15:0] code);
        press_key(4'hC, 1, 2);
        m_digits.delete();
        for (int j = 3; j >= 0; j--) begin
            press_key(code[j*4 +: 4], 1, 2);
            model_edit(code[j*4 +: 4]);
        end
    endtask

    task automatic submit();
        press_key(4'hA, 1, 3);
        m_digits.delete();
    endtask

    task automatic test_reset();
        reset_p   = 1'b1;
        key_valid = 1'b0;
        key_value = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (entry !== 16'h0) begin errors++; $display("FAIL reset_entry: got %h expected 0", entry); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", digit_count); end
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail: got %0d expected 0", fail_count); end
        reset_p = 1'b0;
        m_digits.delete();
        m_fail = 0;
        m_pw   = 16'h1234;
        @(negedge clk);
    endtask

    task automatic test_unlock();
        int n;
        for (int j = 1; j <= 4; j++) begin
            press_key(4'(j), 10, 3);
            model_edit(4'(j));
        end
        checks++; if (entry !== m_entry()) begin errors++; $display("FAIL unlock_entry: got %h expected %h", entry, m_entry()); end
        checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL unlock_count: got %0d expected 4", digit_count); end
        @(negedge clk);
        key_value = 4'hA;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL unlock_early: got %b expected 0", unlocked); end
        @(negedge clk);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_rise: got %b expected 1", unlocked); end
        n = 0;
        while (unlocked === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        m_digits.delete();
        checks++; if (n != 20) begin errors++; $display("FAIL unlock_length: got %0d cycles expected 20", n); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL unlock_fail: got %0d expected 0", fail_count); end
        checks++; if (entry !== 16'h0 || digit_count !== 3'd0) begin
            errors++; $display("FAIL unlock_clear: got %h/%0d expected 0/0", entry, digit_count);
        end
    endtask

    task automatic test_lockout();
        int n;
        int bad;
        press_key(4'h1, 2, 2); press_key(4'h2, 2, 2); press_key(4'h3, 2, 2);
        submit();
        m_fail++;
        checks++; if (fail_count !== 2'(m_fail)) begin errors++; $display("FAIL short_code_fail: got %0d expected %0d", fail_count, m_fail); end
        checks++; if (unlocked !== 1'b0 || entry !== 16'h0) begin
            errors++; $display("FAIL short_code_state: got unlocked %b entry %h expected 0/0", unlocked, entry);
        end
        type_code(16'h1235);
        submit();
        m_fail++;
        checks++; if (fail_count !== 2'(m_fail)) begin errors++; $display("FAIL wrong_code_fail: got %0d expected %0d", fail_count, m_fail); end
        type_code(16'h9999);
        @(negedge clk);
        key_value = 4'hA;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_digits.delete();
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL lockout_rise: got %b expected 1", alarm); end
        n   = 0;
        bad = 0;
        while (alarm === 1'b1 && n < 200) begin
            if (entry !== 16'h0 || digit_count !== 3'd0 || unlocked !== 1'b0) bad++;
            key_value = 4'(n % 13);
            key_valid = (n < 34) && ((n % 6) < 3);
            n++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        m_fail = 0;
        repeat (3) @(negedge clk);
        checks++; if (n != 40) begin errors++; $display("FAIL lockout_length: got %0d cycles expected 40", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL lockout_ignore: got %0d bad samples expected 0", bad); end
        checks++; if (fail_count !== 2'd0 || entry !== 16'h0) begin
            errors++; $display("FAIL lockout_exit: got fail %0d entry %h expected 0/0", fail_count, entry);
        end
    endtask

    task automatic test_edit();
        for (int j = 0; j < 13; j++) begin
            press_key(edit_keys[j], 2, 2);
            checks++; if (entry !== edit_entry[j] || digit_count !== edit_count[j]) begin
                errors++; $display("FAIL edit_step%0d: got %h/%0d expected %h/%0d", j, entry, digit_count, edit_entry[j], edit_count[j]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        key_value = 4'h7;
        key_valid = 1'b1;
        @(negedge clk);
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL edit_latency: got %0d expected 0", digit_count); end
        @(negedge clk);
        checks++; if (digit_count !== 3'd1 || entry !== 16'h7) begin
            errors++; $display("FAIL hold_first: got %h/%0d expected 7/1", entry, digit_count);
        end
        repeat (98) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (digit_count !== 3'd1 || entry !== 16'h7) begin
            errors++; $display("FAIL hold_single: got %h/%0d expected 7/1", entry, digit_count);
        end
        press_key(4'hC, 2, 2);
    endtask

    task automatic test_random();
        int          r;
        int          n;
        logic [3:0]  k;
        logic        exp_open;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 17);
            if (r >= 16) begin
                type_code(m_pw);
                k = 4'hA;
            end else begin
                k = 4'(r);
            end
            if (k == 4'hA) begin
                exp_open = (m_digits.size() == 4) && (m_entry() == m_pw);
                m_digits.delete();
                press_key(k, $urandom_range(1, 3), 3);
                if (exp_open) begin
                    m_fail = 0;
                    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL rnd_unlock%0d: got %b expected 1", i, unlocked); end
                    press_key(4'hC, 1, 3);
                    checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL rnd_relock%0d: got %b expected 0", i, unlocked); end
                end else begin
                    m_fail++;
                    if (m_fail == 3) begin
                        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL rnd_alarm%0d: got %b expected 1", i, alarm); end
                        n = 0;
                        while (alarm === 1'b1 && n < 100) begin
                            n++;
                            @(negedge clk);
                        end
                        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rnd_alarm_end%0d: got %b expected 0", i, alarm); end
                        m_fail = 0;
                    end else begin
                        checks++; if (unlocked !== 1'b0 || alarm !== 1'b0) begin
                            errors++; $display("FAIL rnd_reject%0d: got unlocked %b alarm %b expected 0/0", i, unlocked, alarm);
                        end
                    end
                end
                checks++; if (fail_count !== 2'(m_fail)) begin errors++; $display("FAIL rnd_fail%0d: got %0d expected %0d", i, fail_count, m_fail); end
                checks++; if (entry !== 16'h0 || digit_count !== 3'd0) begin
                    errors++; $display("FAIL rnd_cleared%0d: got %h/%0d expected 0/0", i, entry, digit_count);
                end
            end else begin
                press_key(k, $urandom_range(1, 4), $urandom_range(2, 4));
                model_edit(k);
                checks++; if (entry !== m_entry() || digit_count !== 3'(m_digits.size())) begin
                    errors++; $display("FAIL rnd_edit%0d key %h: got %h/%0d expected %h/%0d", i, k, entry, digit_count, m_entry(), m_digits.size());
                end
            end
        end
        press_key(4'hC, 1, 2);
        m_digits.delete();
    endtask

    task automatic test_reset_mid();
        type_code(16'h1234);
        submit();
        m_fail = 0;
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL rst_pre_unlock: got %b expected 1", unlocked); end
        @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        checks++; if (unlocked !== 1'b0 || alarm !== 1'b0 || entry !== 16'h0 || digit_count !== 3'd0 || fail_count !== 2'd0) begin
            errors++; $display("FAIL rst_unlocked: got u%b a%b e%h c%0d f%0d expected all 0", unlocked, alarm, entry, digit_count, fail_count);
        end
        reset_p = 1'b0;
        type_code(16'h1234);
        submit();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL rst_pw_kept: got %b expected 1", unlocked); end
        press_key(4'hC, 1, 2);
        for (int j = 0; j < 3; j++) begin
            type_code(16'h0000);
            submit();
        end
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL rst_pre_lockout: got %b expected 1", alarm); end
        @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        checks++; if (unlocked !== 1'b0 || alarm !== 1'b0 || entry !== 16'h0 || digit_count !== 3'd0 || fail_count !== 2'd0) begin
            errors++; $display("FAIL rst_lockout: got u%b a%b e%h c%0d f%0d expected all 0", unlocked, alarm, entry, digit_count, fail_count);
        end
        reset_p = 1'b0;
        m_fail  = 0;
        m_pw    = 16'h1234;
        m_digits.delete();
        @(negedge clk);
    endtask

    task automatic test_pw_change();
        type_code(m_pw);
        submit();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL pw_pre_unlock: got %b expected 1", unlocked); end
        press_key(4'hD, 1, 3);
`ifdef KEY_ENTRY_PW_CHANGE_EN
        checks++; if (unlocked !== 1'b0 || digit_count !== 3'd0) begin
            errors++; $display("FAIL pw_setpw_enter: got unlocked %b count %0d expected 0/0", unlocked, digit_count);
        end
        for (int j = 9; j >= 6; j--) begin
            press_key(4'(j), 1, 2);
            model_edit(4'(j));
        end
        checks++; if (entry !== m_entry() || digit_count !== 3'd4) begin
            errors++; $display("FAIL pw_setpw_buffer: got %h/%0d expected %h/4", entry, digit_count, m_entry());
        end
        m_pw = m_entry();
        submit();
        checks++; if (unlocked !== 1'b0 || entry !== 16'h0) begin
            errors++; $display("FAIL pw_commit: got unlocked %b entry %h expected 0/0", unlocked, entry);
        end
        type_code(16'h9876);
        submit();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL pw_new_unlocks: got %b expected 1", unlocked); end
        press_key(4'hC, 1, 2);
        type_code(16'h1234);
        submit();
        m_fail++;
        checks++; if (unlocked !== 1'b0 || fail_count !== 2'(m_fail)) begin
            errors++; $display("FAIL pw_old_rejected: got unlocked %b fail %0d expected 0/%0d", unlocked, fail_count, m_fail);
        end
`else
        checks++; if (unlocked !== 1'b1 || digit_count !== 3'd0) begin
            errors++; $display("FAIL pw_d_ignored: got unlocked %b count %0d expected 1/0", unlocked, digit_count);
        end
        press_key(4'hC, 1, 2);
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL pw_relock: got %b expected 0", unlocked); end
        type_code(16'h1234);
        submit();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL pw_still_1234: got %b expected 1", unlocked); end
        press_key(4'hC, 1, 2);
`endif
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_edit();
        test_hold();
        test_random();
        test_reset_mid();
        test_pw_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_entry_lock.md
# key_entry_lock

Keypad code-entry controller that sits directly downstream of the 4x4 keypad scanner. It consumes the scanner's `key_value`/`key_valid` pair, converts each press into one event, and accumulates digits into an entry buffer. Enter, backspace and clear keys edit or submit the buffer. On submit it compares the buffer against a stored password and drives unlock and lockout indications to the display/actuator logic.

## Interface
- `DIGITS`, 4: password length in hex nibbles (1..8).
- `PASSWORD`, 16'h1234: reset-value password, `DIGITS*4` bits.
- `UNLOCK_CYCLES`, 500_000_000: clocks `unlocked` stays high.
- `LOCK_CYCLES`, 1_000_000_000: clocks of lockout after too many failures.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout.

- `clk` in 1: system clock.
- `reset_p` in 1: synchronous, active-high reset.
- `key_value` in 4: scanner key code; valid while `key_valid`=1.
- `key_valid` in 1: level, high for the whole duration of a press.
- `entry` out `DIGITS*4`: entry buffer; newest digit in the low nibble.
- `digit_count` out `$clog2(DIGITS+1)`: number of digits in the buffer.
- `unlocked` out 1: high while the state is UNLOCKED.
- `alarm` out 1: high while the state is LOCKOUT.
- `fail_count` out `$clog2(MAX_FAIL+1)`: consecutive failed submits.

## Operation
- Press event:
  - `key_valid` is registered as `kv_d`.
  - `press = key_valid & ~kv_d`, giving exactly one event per press regardless of hold length.
  - `key_value` is sampled in the `press` cycle.
- Key map:
  - 0x0–0x9: digits.
  - 0xA: enter.
  - 0xB: backspace.
  - 0xC: clear/relock.
  - 0xD: set-password (see Configuration).
  - 0xE, 0xF: ignored.
- States: ENTRY, CHECK, UNLOCKED, LOCKOUT, SET_PW.
- ENTRY:
  - Digit with `digit_count<DIGITS`: `entry={entry[..-4],digit}`, count+1.
  - Digit with buffer full: ignored, no change.
  - Backspace: `entry>>4`, count-1; no-op at count 0.
  - Clear: entry=0, count=0.
  - Enter: go to CHECK.
- CHECK (exactly 1 cycle):
  - Match means `digit_count==DIGITS` and `entry==pw_reg`.
  - Match: go to UNLOCKED, clear `fail_count`.
  - Otherwise: `fail_count`+1. If the new value equals `MAX_FAIL`, go to LOCKOUT; else return to ENTRY.
  - Leaving CHECK always clears entry and count.
- UNLOCKED:
  - Timer loads `UNLOCK_CYCLES-1` on entry and counts down.
  - At 0, or on a clear press: go to ENTRY.
  - Digits, enter and backspace are ignored.
- LOCKOUT:
  - Timer loads `LOCK_CYCLES-1` and counts down; all presses are ignored.
  - At 0: go to ENTRY and clear `fail_count`.
- Presses arriving in CHECK are dropped.
- Timer expiry and a press in the same cycle: expiry wins and the press is dropped.
- Timer is 32 bits, shared by UNLOCKED and LOCKOUT.

## Timing
- Reset values:
  - State ENTRY.
  - `entry`=0, `digit_count`=0, `fail_count`=0.
  - `unlocked`=0, `alarm`=0.
  - `pw_reg`=`PASSWORD`, `kv_d`=0.
- Reset has priority in every state, including mid-timer and SET_PW; an uncommitted new password is lost.
- All outputs are registered.
- Edit latency: `entry`/`digit_count` update 1 clock after the first rising edge at which `key_valid` is sampled high.
- Enter to result: `unlocked` or `alarm` rises 2 clocks after the enter press is sampled (1 clock into CHECK, 1 clock out).
- `unlocked` stays high for exactly `UNLOCK_CYCLES` clocks if not cleared. `alarm` stays high for exactly `LOCK_CYCLES` clocks.
- `key_valid` still held across a state change generates no new event.

## Configuration
- Macro: `KEY_ENTRY_PW_CHANGE_EN`.
- Defined:
  - Key 0xD in UNLOCKED goes to SET_PW, with entry and count cleared and the timer stopped.
  - SET_PW edits the buffer exactly as ENTRY does.
  - Enter with `digit_count==DIGITS`: `pw_reg<=entry`, go to ENTRY.
  - Enter with fewer digits: ignored.
  - Clear: abort to ENTRY, `pw_reg` unchanged.
  - `unlocked` is 0 in SET_PW.
- Undefined: SET_PW does not exist, 0xD is ignored everywhere, and `pw_reg` is the constant `PASSWORD`.

## Structure
- Package `key_entry_pkg`:
  - State encoding, one-hot 5 bits.
  - Key-code constants `KEY_ENTER`, `KEY_BACK`, `KEY_CLEAR`, `KEY_SETPW`.
- Sub-module `key_press_edge`: registers `key_valid` and emits the single-cycle `press` pulse plus the latched `key_value`.
- FSM, buffer and timer live in the top module.

## Test plan
Benches override `UNLOCK_CYCLES=20`, `LOCK_CYCLES=40`.
1. Press 1,2,3,4, enter (each held 10 clk) -> `entry`=16'h1234 before enter; `unlocked`=1 for exactly 20 clk; `fail_count`=0.
2. Press 1,2,3, enter -> no unlock, `fail_count`=1, `entry`=0. Press 1,2,3,5, enter -> `fail_count`=2. A third wrong code -> `alarm`=1 for 40 clk, presses ignored throughout, then `fail_count`=0.
3. Press 1,2,3,4,5 -> fifth digit ignored, `entry`=16'h1234. Backspace x5 -> count saturates at 0. Clear mid-entry -> `entry`=0.
4. Hold `key_valid` with 0x7 for 100 clk -> `digit_count`=1 only.
5. Assert `reset_p` during unlock and during lockout -> next clk all outputs at reset values, `pw_reg`=16'h1234.
6. With `KEY_ENTRY_PW_CHANGE_EN`: unlock, press D, 9,8,7,6, enter -> code 9876 unlocks and code 1234 fails. Without the macro, D is ignored and 1234 still unlocks.
